// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_ctrl_pkg;

    localparam int DEF_DATA_SIZE   = 32;
    localparam int DEF_ADDR_SIZE   = 10;
    localparam int CYCLES_PER_ELEM = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_A,
        ST_READ_B,
        ST_ADD,
        ST_WRITE,
        ST_DONE
    } calc_state_e;

endpackage

// File: rtl/calc_addr_gen.sv
// Read/write address counters for one job: load on start, step once per
// element, wrap the write pointer at the configured end address.
module calc_addr_gen #(
    parameter int AddrSize = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [AddrSize-1:0] rd_start_i,
    input  logic [AddrSize-1:0] rd_end_i,
    input  logic [AddrSize-1:0] wr_start_i,
    input  logic [AddrSize-1:0] wr_end_i,
    output logic [AddrSize-1:0] rd_addr_o,
    output logic [AddrSize-1:0] wr_addr_o,
    output logic                last_o
);

    localparam logic [AddrSize-1:0] ONE = 1;

    logic [AddrSize-1:0] rd_addr_q;
    logic [AddrSize-1:0] wr_addr_q;
    logic [AddrSize-1:0] rd_end_q;
    logic [AddrSize-1:0] wr_start_q;
    logic [AddrSize-1:0] wr_end_q;

    assign rd_addr_o = rd_addr_q;
    assign wr_addr_o = wr_addr_q;
    assign last_o    = (rd_addr_q == rd_end_q);

    // Counter registers; the read pointer holds on the last element so a
    // range ending at the top of the address space never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_end_q   <= '0;
            wr_start_q <= '0;
            wr_end_q   <= '0;
        end else if (load_i) begin
            rd_addr_q  <= rd_start_i;
            wr_addr_q  <= wr_start_i;
            rd_end_q   <= rd_end_i;
            wr_start_q <= wr_start_i;
            wr_end_q   <= wr_end_i;
        end else if (step_i) begin
            if (!last_o) begin
                rd_addr_q <= rd_addr_q + ONE;
            end
            wr_addr_q <= (wr_addr_q == wr_end_q) ? wr_start_q : wr_addr_q + ONE;
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Sequencer: reads A and B operands per address, adds them and writes the
// zero-extended sum to the selected SRAM. All outputs come from flops that
// are loaded from the current state, so they appear one cycle after it.
module calc_controller
    import calc_ctrl_pkg::*;
#(
    parameter int DataSize = DEF_DATA_SIZE,
    parameter int AddrSize = DEF_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [AddrSize-1:0]   read_start_addr,
    input  logic [AddrSize-1:0]   read_end_addr,
    input  logic [AddrSize-1:0]   write_start_addr,
    input  logic [AddrSize-1:0]   write_end_addr,
    input  logic                  dest_sel,
    input  logic [DataSize*2-1:0] rd_data,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic                  loc_sel,
    output logic [AddrSize-1:0]   curr_rd_addr,
    output logic [AddrSize-1:0]   curr_wr_addr,
    output logic [DataSize*2-1:0] wr_data,
    output logic                  ready,
    output logic                  done,
    output logic                  cfg_err
);

    calc_state_e state_q, state_d;

    logic                  dest_q;
    logic                  err_q;
    logic [DataSize-1:0]   op_a_q;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  loc_sel_q, loc_sel_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  cfg_err_q;
    logic [AddrSize-1:0]   curr_rd_addr_q;
    logic [AddrSize-1:0]   curr_wr_addr_q;
    logic [DataSize*2-1:0] wr_data_q;

    logic                  load;
    logic                  step;
    logic                  last;
    logic                  range_bad;
    logic [AddrSize-1:0]   rd_addr;
    logic [AddrSize-1:0]   wr_addr;
    logic [DataSize:0]     sum;
    logic                  unused_rd_hi;

    assign range_bad    = (read_end_addr < read_start_addr);
    assign sum          = {1'b0, op_a_q} + {1'b0, rd_data[DataSize-1:0]};
    assign unused_rd_hi = ^rd_data[DataSize*2-1:DataSize];

    calc_addr_gen #(
        .AddrSize (AddrSize)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
        .step_i     (step),
        .rd_start_i (read_start_addr),
        .rd_end_i   (read_end_addr),
        .wr_start_i (write_start_addr),
        .wr_end_i   (write_end_addr),
        .rd_addr_o  (rd_addr),
        .wr_addr_o  (wr_addr),
        .last_o     (last)
    );

    // Next-state and output decode for the element sequence.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        loc_sel_d = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    if (range_bad) begin
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_READ_A;
                    end
                end
            end
            ST_READ_A: begin
                rd_en_d = 1'b1;
                state_d = ST_READ_B;
            end
            ST_READ_B: begin
                rd_en_d   = 1'b1;
                loc_sel_d = 1'b1;
                state_d   = ST_ADD;
            end
            ST_ADD: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en_d   = 1'b1;
                loc_sel_d = dest_q;
                step      = 1'b1;
                state_d   = last ? ST_DONE : ST_READ_A;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, job configuration, operand capture and registered outputs.
    // Because the read enable is itself registered, operand A is on rd_data
    // while in ADD and operand B while in WRITE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            dest_q         <= 1'b0;
            err_q          <= 1'b0;
            op_a_q         <= '0;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            loc_sel_q      <= 1'b0;
            done_q         <= 1'b0;
            ready_q        <= 1'b1;
            cfg_err_q      <= 1'b0;
            curr_rd_addr_q <= '0;
            curr_wr_addr_q <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            wr_en_q        <= wr_en_d;
            loc_sel_q      <= loc_sel_d;
            done_q         <= done_d;
            ready_q        <= ready_d;
            cfg_err_q      <= err_q;
            curr_rd_addr_q <= rd_addr;
            curr_wr_addr_q <= wr_addr;
            if (state_q == ST_IDLE && start) begin
                err_q <= range_bad;
                if (!range_bad) begin
                    dest_q <= dest_sel;
                end
            end
            if (state_q == ST_ADD) begin
                op_a_q <= rd_data[DataSize-1:0];
            end
            if (state_q == ST_WRITE) begin
                wr_data_q <= {{(DataSize-1){1'b0}}, sum};
            end
        end
    end

    assign rd_en        = rd_en_q;
    assign wr_en        = wr_en_q;
    assign loc_sel      = loc_sel_q;
    assign done         = done_q;
    assign ready        = ready_q;
    assign cfg_err      = cfg_err_q;
    assign curr_rd_addr = curr_rd_addr_q;
    assign curr_wr_addr = curr_wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule
